// File: rtl/control_pkg.sv
// Shared opcode/state encodings, default field widths and decode helpers for the sequenced control unit.
package control_pkg;

    localparam int OP_W_DEF    = 6;
    localparam int INSTR_W_DEF = 32;
    localparam int REG_AW_DEF  = 3;
    localparam int IMM_W_DEF   = 8;

    typedef enum logic [OP_W_DEF-1:0] {
        OP_ADD    = OP_W_DEF'(1),
        OP_SUB    = OP_W_DEF'(2),
        OP_MOV    = OP_W_DEF'(3),
        OP_DIV    = OP_W_DEF'(4),
        OP_MUL    = OP_W_DEF'(5),
        OP_AND    = OP_W_DEF'(6),
        OP_OR     = OP_W_DEF'(7),
        OP_STR_DM = OP_W_DEF'(8),
        OP_LDR_DM = OP_W_DEF'(9),
        OP_STR_IM = OP_W_DEF'(10),
        OP_LDR_IM = OP_W_DEF'(11)
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY
    } state_e;

    typedef struct packed {
        logic [OP_W_DEF-1:0]   op;
        logic [REG_AW_DEF-1:0] rd;
        logic [REG_AW_DEF-1:0] r1;
        logic [REG_AW_DEF-1:0] r2;
        logic [IMM_W_DEF-1:0]  i1;
        logic [IMM_W_DEF-1:0]  i2;
    } decode_t;

    function automatic logic is_legal(input logic [OP_W_DEF-1:0] op);
        return (op >= OP_ADD) && (op <= OP_LDR_IM);
    endfunction

    function automatic logic is_alu(input logic [OP_W_DEF-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_DIV) ||
               (op == OP_MUL) || (op == OP_AND) || (op == OP_OR);
    endfunction

    // Register-file result writes: every ALU op plus the data-memory load.
    function automatic logic writes_rf(input logic [OP_W_DEF-1:0] op);
        return is_alu(op) || (op == OP_LDR_DM);
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Pointer that advances on en_i and wraps DEPTH-1 -> 0; wrap_o is a registered pulse on the wrapped value.
// Latency 1 from en_i; no backpressure.
module wrap_counter
    import control_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o
);

    logic [W-1:0] count_q;
    logic         wrap_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (en_i) begin
                if (count_q == W'(DEPTH - 1)) begin
                    count_q <= '0;
                    wrap_q  <= 1'b1;
                end else begin
                    count_q <= count_q + W'(1);
                end
            end
        end
    end

    assign count_o = count_q;
    assign wrap_o  = wrap_q;

endmodule

// File: rtl/control_unit_seq.sv
// Registered decoder: one instruction per valid/ready transfer, fields and one-cycle strobes 1 cycle later.
// Full throughput for single-cycle ops; ready drops while MUL/DIV run, rwe deferred to the last busy cycle.
module control_unit_seq
    import control_pkg::*;
#(
    parameter int OP_W     = OP_W_DEF,
    parameter int INSTR_W  = INSTR_W_DEF,
    parameter int REG_AW   = REG_AW_DEF,
    parameter int IMM_W    = IMM_W_DEF,
    parameter int IM_DEPTH = 65536,
    parameter int MUL_CYC  = 2,
    parameter int DIV_CYC  = 8,
    localparam int PTR_W   = (IM_DEPTH > 1) ? $clog2(IM_DEPTH) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               instr_valid_i,
    output logic               instr_ready_o,
    input  logic [INSTR_W-1:0] instr_i,
    output logic [OP_W-1:0]    alu_ctrl_o,
    output logic [REG_AW-1:0]  rd_o,
    output logic [REG_AW-1:0]  r1_o,
    output logic [REG_AW-1:0]  r2_o,
    output logic [IMM_W-1:0]   i1_o,
    output logic [IMM_W-1:0]   i2_o,
    output logic               rwe_o,
    output logic               rwe_imm_o,
    output logic               dm_we_o,
    output logic               im_re_o,
    output logic               im_we_o,
    output logic [PTR_W-1:0]   im_raddr_o,
    output logic [PTR_W-1:0]   im_waddr_o,
    output logic               frame_done_o,
    output logic               illegal_o
);

    localparam int CYC_MAX = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
    localparam int CNT_W   = $clog2(CYC_MAX + 1);

    decode_t            dec;
    logic               accept;
    logic               long_op;
    logic [CNT_W-1:0]   op_cnt;
    logic               unused_instr;

    state_e             state_q;
    logic               ready_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [OP_W-1:0]    alu_q;
    decode_t            fld_q;
    logic               rwe_q;
    logic               rwe_imm_q;
    logic               dm_we_q;
    logic               im_re_q;
    logic               im_we_q;
    logic               illegal_q;

    always_comb begin
        dec.op = instr_i[INSTR_W-1 -: OP_W];
        dec.rd = instr_i[INSTR_W-OP_W-1 -: REG_AW];
        dec.r1 = instr_i[INSTR_W-OP_W-REG_AW-1 -: REG_AW];
        dec.r2 = instr_i[INSTR_W-OP_W-2*REG_AW-1 -: REG_AW];
        dec.i1 = instr_i[2*IMM_W-1:IMM_W];
        dec.i2 = instr_i[IMM_W-1:0];
    end

    assign unused_instr = ^instr_i[INSTR_W-OP_W-3*REG_AW-1:2*IMM_W];
    assign accept       = instr_valid_i && ready_q;

    // A 1-cycle MUL/DIV behaves exactly like any other single-cycle op.
    assign long_op = ((dec.op == OP_MUL) && (MUL_CYC > 1)) ||
                     ((dec.op == OP_DIV) && (DIV_CYC > 1));
    assign op_cnt  = (dec.op == OP_MUL) ? CNT_W'(MUL_CYC - 1) : CNT_W'(DIV_CYC - 1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            cnt_q     <= '0;
            alu_q     <= '0;
            fld_q     <= '0;
            rwe_q     <= 1'b0;
            rwe_imm_q <= 1'b0;
            dm_we_q   <= 1'b0;
            im_re_q   <= 1'b0;
            im_we_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            rwe_q     <= 1'b0;
            rwe_imm_q <= 1'b0;
            dm_we_q   <= 1'b0;
            im_re_q   <= 1'b0;
            im_we_q   <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                IDLE, ISSUE: begin
                    if (accept) begin
                        fld_q <= dec;
                        if (!is_legal(dec.op)) begin
                            alu_q     <= '0;
                            illegal_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            alu_q     <= is_alu(dec.op) ? dec.op : '0;
                            rwe_imm_q <= (dec.op == OP_MOV);
                            dm_we_q   <= (dec.op == OP_STR_DM);
                            im_we_q   <= (dec.op == OP_STR_IM);
                            im_re_q   <= (dec.op == OP_LDR_IM);
                            state_q   <= ISSUE;
                            if (long_op) begin
                                ready_q <= 1'b0;
                                cnt_q   <= op_cnt;
                            end else begin
                                rwe_q <= writes_rf(dec.op);
                            end
                        end
                    end else if (!ready_q) begin
                        state_q <= BUSY;
                        cnt_q   <= cnt_q - CNT_W'(1);
                        rwe_q   <= (cnt_q == CNT_W'(1));
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        rwe_q <= (cnt_q == CNT_W'(1));
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    wrap_counter #(.DEPTH(IM_DEPTH), .W(PTR_W)) u_rd_ptr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (im_re_q),
        .count_o (im_raddr_o),
        .wrap_o  ()
    );

    wrap_counter #(.DEPTH(IM_DEPTH), .W(PTR_W)) u_wr_ptr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (im_we_q),
        .count_o (im_waddr_o),
        .wrap_o  (frame_done_o)
    );

    assign instr_ready_o = ready_q;
    assign alu_ctrl_o    = alu_q;
    assign rd_o          = fld_q.rd;
    assign r1_o          = fld_q.r1;
    assign r2_o          = fld_q.r2;
    assign i1_o          = fld_q.i1;
    assign i2_o          = fld_q.i2;
    assign rwe_o         = rwe_q;
    assign rwe_imm_o     = rwe_imm_q;
    assign dm_we_o       = dm_we_q;
    assign im_re_o       = im_re_q;
    assign im_we_o       = im_we_q;
    assign illegal_o     = illegal_q;

endmodule

// File: tb/tb_control_unit_seq.sv
// Directed and random stimulus against a cycle-schedule reference model of the sequenced control unit.
module tb_control_unit_seq;

    localparam int IMD  = 4;
    localparam int MULC = 2;
    localparam int DIVC = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [5:0]  alu_ctrl;
    logic [2:0]  rd, r1, r2;
    logic [7:0]  i1, i2;
    logic        rwe, rwe_imm, dm_we, im_re, im_we, frame_done, illegal;
    logic [1:0]  im_raddr, im_waddr;

    always #5 clk = ~clk;

    control_unit_seq #(.IM_DEPTH(IMD), .MUL_CYC(MULC), .DIV_CYC(DIVC)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .instr_valid_i (instr_valid),
        .instr_ready_o (instr_ready),
        .instr_i       (instr),
        .alu_ctrl_o    (alu_ctrl),
        .rd_o          (rd),
        .r1_o          (r1),
        .r2_o          (r2),
        .i1_o          (i1),
        .i2_o          (i2),
        .rwe_o         (rwe),
        .rwe_imm_o     (rwe_imm),
        .dm_we_o       (dm_we),
        .im_re_o       (im_re),
        .im_we_o       (im_we),
        .im_raddr_o    (im_raddr),
        .im_waddr_o    (im_waddr),
        .frame_done_o  (frame_done),
        .illegal_o     (illegal)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: expected outputs for the current cycle, plus absolute-cycle schedule of busy/rwe.
    int         cyc;
    int         busy_until;
    int         rwe_at;
    logic       e_ready, e_rwe, e_rwe_imm, e_dm_we, e_im_re, e_im_we, e_frame, e_illegal;
    logic [5:0] e_alu;
    logic [2:0] e_rd, e_r1, e_r2;
    logic [7:0] e_i1, e_i2;
    int         e_raddr, e_waddr;

    int         n_rwe, n_low, n_frame;
    int         wq[$];
    logic [4:0] pat;

    function automatic logic [31:0] mk(input int op, input int a, input int b, input int c,
                                       input int x, input int y);
        logic [5:0] o  = 6'(op);
        logic [2:0] ra = 3'(a);
        logic [2:0] rb = 3'(b);
        logic [2:0] rc = 3'(c);
        logic [7:0] ia = 8'(x);
        logic [7:0] ib = 8'(y);
        return {o, ra, rb, rc, 1'b0, ia, ib};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        busy_until = -1;
        rwe_at     = -1;
        e_ready    = 1'b1;
        {e_rwe, e_rwe_imm, e_dm_we, e_im_re, e_im_we, e_frame, e_illegal} = '0;
        e_alu = '0; e_rd = '0; e_r1 = '0; e_r2 = '0; e_i1 = '0; e_i2 = '0;
        e_raddr = 0; e_waddr = 0;
    endtask

    task automatic model_step(input logic v, input logic [31:0] ins);
        logic [5:0] op;
        int         n;
        logic       n_fd;
        n_fd = 1'b0;
        if (e_im_re) e_raddr = (e_raddr + 1) % IMD;
        if (e_im_we) begin
            e_waddr = (e_waddr + 1) % IMD;
            n_fd    = (e_waddr == 0);
        end
        {e_rwe_imm, e_dm_we, e_im_re, e_im_we, e_illegal} = '0;
        if (v && e_ready) begin
            op   = ins[31:26];
            e_rd = ins[25:23]; e_r1 = ins[22:20]; e_r2 = ins[19:17];
            e_i1 = ins[15:8];  e_i2 = ins[7:0];
            if (op == 0 || op > 11) begin
                e_illegal = 1'b1;
                e_alu     = '0;
            end else begin
                e_alu     = (op inside {1, 2, 4, 5, 6, 7}) ? op : 6'd0;
                e_rwe_imm = (op == 3);
                e_dm_we   = (op == 8);
                e_im_we   = (op == 10);
                e_im_re   = (op == 11);
                n = (op == 5) ? MULC : (op == 4) ? DIVC : 1;
                if (op inside {1, 2, 4, 5, 6, 7, 9}) rwe_at = cyc + n;
                if (n > 1) busy_until = cyc + n;
            end
        end
        cyc++;
        e_rwe   = (rwe_at == cyc);
        e_ready = !(cyc <= busy_until);
        e_frame = n_fd;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ready"},   32'(instr_ready), 32'(e_ready));
        chk({tag, ".alu"},     32'(alu_ctrl),    32'(e_alu));
        chk({tag, ".rd"},      32'(rd),          32'(e_rd));
        chk({tag, ".r1"},      32'(r1),          32'(e_r1));
        chk({tag, ".r2"},      32'(r2),          32'(e_r2));
        chk({tag, ".i1"},      32'(i1),          32'(e_i1));
        chk({tag, ".i2"},      32'(i2),          32'(e_i2));
        chk({tag, ".rwe"},     32'(rwe),         32'(e_rwe));
        chk({tag, ".rwe_imm"}, 32'(rwe_imm),     32'(e_rwe_imm));
        chk({tag, ".dm_we"},   32'(dm_we),       32'(e_dm_we));
        chk({tag, ".im_re"},   32'(im_re),       32'(e_im_re));
        chk({tag, ".im_we"},   32'(im_we),       32'(e_im_we));
        chk({tag, ".raddr"},   32'(im_raddr),    32'(e_raddr));
        chk({tag, ".waddr"},   32'(im_waddr),    32'(e_waddr));
        chk({tag, ".frame"},   32'(frame_done),  32'(e_frame));
        chk({tag, ".illegal"}, 32'(illegal),     32'(e_illegal));
    endtask

    // One clock cycle: drive inputs, compare this cycle's outputs, advance the model and the clock.
    task automatic cycle(input logic v, input logic [31:0] ins, input string tag);
        instr_valid = v;
        instr       = ins;
        check_all(tag);
        n_rwe   += int'(rwe);
        n_low   += int'(!instr_ready);
        n_frame += int'(frame_done);
        pat = {pat[3:0], rwe};
        if (im_we) wq.push_back(int'(im_waddr));
        model_step(v, ins);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) cycle(1'b0, 32'h0, tag);
    endtask

    initial begin
        logic        acc;
        int          iters;
        logic [31:0] ri;
        int          rop;

        cyc = 0;
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // 1. reset state, then a single ADD
        check_all("reset");
        rst = 1'b0;
        cycle(1'b1, mk(1, 2, 1, 3, 0, 0), "t1_add");
        chk("t1_alu", 32'(alu_ctrl), 32'h1);
        chk("t1_rd", 32'(rd), 32'd2);
        chk("t1_rwe", 32'(rwe), 32'd1);
        idle(1, "t1_idle");
        chk("t1_rwe_drop", 32'(rwe), 32'd0);
        idle(1, "t1_idle");

        // 2. back-to-back single-cycle ops
        n_low = 0;
        pat   = '0;
        cycle(1'b1, mk(1, 1, 2, 3, 0, 0), "t2_add");
        cycle(1'b1, mk(2, 4, 5, 6, 0, 0), "t2_sub");
        cycle(1'b1, mk(6, 7, 0, 1, 0, 0), "t2_and");
        idle(2, "t2_idle");
        chk("t2_rwe_pattern", 32'(pat), 32'b01110);
        chk("t2_ready_low", 32'(n_low), 32'd0);

        // 3. DIV stalls; a held OR waits
        n_low = 0;
        n_rwe = 0;
        cycle(1'b1, mk(4, 3, 1, 2, 0, 0), "t3_div");
        iters = 0;
        acc   = 1'b0;
        while (!acc && iters < 20) begin
            acc = instr_ready;
            cycle(1'b1, mk(7, 5, 6, 7, 0, 0), "t3_or");
            iters++;
        end
        chk("t3_or_accepted", 32'(acc), 32'd1);
        chk("t3_or_wait_cycles", 32'(iters), 32'd9);
        chk("t3_ready_low", 32'(n_low), 32'd8);
        chk("t3_div_rwe_count", 32'(n_rwe), 32'd1);
        idle(3, "t3_idle");

        // 4. image write pointer wrap
        wq.delete();
        n_frame = 0;
        for (int k = 0; k < 5; k++) cycle(1'b1, mk(10, 0, 0, 0, 0, k), "t4_str_im");
        idle(3, "t4_idle");
        chk("t4_we_count", 32'(wq.size()), 32'd5);
        for (int k = 0; k < 5 && k < wq.size(); k++) chk("t4_waddr_seq", 32'(wq[k]), 32'(k % IMD));
        chk("t4_frame_count", 32'(n_frame), 32'd1);

        // 5. illegal opcode, then MOV
        cycle(1'b1, mk(63, 1, 1, 1, 0, 0), "t5_illegal");
        chk("t5_illegal", 32'(illegal), 32'd1);
        chk("t5_no_im_we", 32'(im_we), 32'd0);
        chk("t5_waddr_kept", 32'(im_waddr), 32'd1);
        cycle(1'b1, mk(3, 2, 0, 0, 0, 8'hA5), "t5_mov");
        chk("t5_rwe_imm", 32'(rwe_imm), 32'd1);
        chk("t5_i2", 32'(i2), 32'hA5);
        idle(2, "t5_idle");

        // 6. reset in the middle of a MUL
        cycle(1'b1, mk(5, 4, 1, 2, 0, 0), "t6_mul");
        instr_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("t6_in_reset");
        @(posedge clk);
        #1;
        rst   = 1'b0;
        n_rwe = 0;
        idle(5, "t6_after");
        chk("t6_no_rwe", 32'(n_rwe), 32'd0);

        // Random traffic, including MUL/DIV stalls, held valids and illegal opcodes
        for (int k = 0; k < 400; k++) begin
            rop = ($urandom_range(15) == 0) ? (($urandom_range(1) == 0) ? 0 : int'($urandom_range(63, 12)))
                                             : int'($urandom_range(11, 1));
            ri  = mk(rop, $urandom_range(7), $urandom_range(7), $urandom_range(7),
                     $urandom_range(255), $urandom_range(255));
            cycle($urandom_range(3) != 0, ri, "rand");
        end
        idle(DIVC + 2, "rand_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
